// File: rtl/sub3_complex_pipe_pkg.sv
// Shared definitions for the three-operand complex subtractor pipeline.
//   - Default Q format and the derived width, plus MAXV/MINV for that width.
//   - sub_rule(): one W-bit two's complement subtract with overflow detect
//     and optional saturation. Width is a run-time argument so the same
//     function serves any parameterisation of the pipeline.
package sub3_complex_pkg;

  localparam int unsigned DefQi = 3;
  localparam int unsigned DefQf = 3;
  localparam int unsigned W     = DefQi + DefQf;

  // Largest and smallest value representable in a w-bit signed word.
  function automatic int max_of(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int min_of(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  localparam int MAXV = max_of(W);
  localparam int MINV = min_of(W);

  typedef struct packed {
    logic signed [31:0] val;
    logic               ovf;
  } sub_res_t;

  // a and b are w-bit values sign-extended to 32 bits; w must be <= 31.
  // The exact difference fits in 32 bits, so overflow is simply "the
  // w-bit wrapped result differs from the exact one".
  function automatic sub_res_t sub_rule(input int unsigned      w,
                                        input bit               sat,
                                        input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    sub_res_t           res;
    logic signed [31:0] diff;
    logic signed [31:0] wrapped;
    int unsigned        sh;
    diff    = a - b;
    sh      = 32 - w;
    wrapped = (diff <<< sh) >>> sh;
    res.ovf = (wrapped != diff);
    res.val = wrapped;
    // An overflowing subtract can only go positive when the minuend is
    // non-negative, so the minuend sign picks the rail.
    if (sat && res.ovf) begin
      res.val = a[31] ? min_of(w) : max_of(w);
    end
    return res;
  endfunction

endpackage

// File: rtl/sub3_complex_pipe_if.sv
// Stream bundle for sub3_complex_pipe.
//   Input side : in_valid/in_ready handshake carrying operands a, b, c (Re/Im).
//   Output side: out_valid/out_ready handshake carrying d (Re/Im) and ovf.
//   Status     : ovf_sticky, out_count; control ovf_clr.
// master = the block feeding and draining the pipe; slave = the pipe itself.
interface sub3_complex_pipe_if #(
  parameter int unsigned W     = 6,
  parameter int unsigned CNT_W = 16
);

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a_Re;
  logic signed [W-1:0] a_Im;
  logic signed [W-1:0] b_Re;
  logic signed [W-1:0] b_Im;
  logic signed [W-1:0] c_Re;
  logic signed [W-1:0] c_Im;

  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] d_Re;
  logic signed [W-1:0] d_Im;
  logic                ovf;

  logic                ovf_sticky;
  logic                ovf_clr;
  logic [CNT_W-1:0]    out_count;

  modport master (
    output in_valid, a_Re, a_Im, b_Re, b_Im, c_Re, c_Im, out_ready, ovf_clr,
    input  in_ready, out_valid, d_Re, d_Im, ovf, ovf_sticky, out_count
  );

  modport slave (
    input  in_valid, a_Re, a_Im, b_Re, b_Im, c_Re, c_Im, out_ready, ovf_clr,
    output in_ready, out_valid, d_Re, d_Im, ovf, ovf_sticky, out_count
  );

endinterface

// File: rtl/sub3_complex_pipe_sub2_sat.sv
// sub2_sat: combinational W-bit signed subtract d_o = a_i - b_i.
//   a_i, b_i : W-bit signed operands (minuend, subtrahend)
//   d_o      : W-bit result, wrapped (SAT=0) or saturated (SAT=1)
//   ovf_o    : high when the exact difference is not representable
module sub2_sat
  import sub3_complex_pkg::*;
#(
  parameter int unsigned W   = 6,
  parameter int unsigned SAT = 0
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] d_o,
  output logic                ovf_o
);

  sub_res_t           res;
  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;

  always_comb begin
    a_ext = {{(32 - W){a_i[W-1]}}, a_i};
    b_ext = {{(32 - W){b_i[W-1]}}, b_i};
    res   = sub_rule(W, (SAT != 0), a_ext, b_ext);
    d_o   = res.val[W-1:0];
    ovf_o = res.ovf;
  end

endmodule

// File: rtl/sub3_complex_pipe.sv
// sub3_complex_pipe: streaming complex d = a - b - c in QI.QF two's complement.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards everything in flight
//   bus   : slave side of sub3_complex_pipe_if
//           in_valid/in_ready + a, b, c  -> stage 1 (p = a - b, c carried along)
//           stage 2 (d = p - c) -> out_valid/out_ready + d, ovf
//           ovf_sticky (set wins over ovf_clr), out_count (accepted outputs)
// Two registered stages, one result per cycle, in_ready is combinational from
// out_ready (no skid buffer), so at most two triples are ever held.
module sub3_complex_pipe
  import sub3_complex_pkg::*;
#(
  parameter int unsigned QI    = DefQi,
  parameter int unsigned QF    = DefQf,
  parameter int unsigned SAT   = 0,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  sub3_complex_pipe_if.slave bus
);

  localparam int unsigned Wd = QI + QF;

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic signed [Wd-1:0] p_re_q, p_re_d, p_im_q, p_im_d;
  logic signed [Wd-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
  logic              ovf1_q, ovf1_d;

  // Output stage state
  logic              out_valid_q, out_valid_d;
  logic signed [Wd-1:0] d_re_q, d_re_d, d_im_q, d_im_d;
  logic              ovf_q, ovf_d;

  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Subtractor results
  logic signed [Wd-1:0] p_re, p_im, d_re, d_im;
  logic              ovf1_re, ovf1_im, ovf2_re, ovf2_im;

  logic s2_adv;
  logic in_ready;
  logic in_hs;
  logic out_acc;

  sub2_sat #(.W(Wd), .SAT(SAT)) u_s1_re (
    .a_i  (bus.a_Re),
    .b_i  (bus.b_Re),
    .d_o  (p_re),
    .ovf_o(ovf1_re)
  );

  sub2_sat #(.W(Wd), .SAT(SAT)) u_s1_im (
    .a_i  (bus.a_Im),
    .b_i  (bus.b_Im),
    .d_o  (p_im),
    .ovf_o(ovf1_im)
  );

  // Stage 2 works on the registered (already saturated, if SAT) p.
  sub2_sat #(.W(Wd), .SAT(SAT)) u_s2_re (
    .a_i  (p_re_q),
    .b_i  (c_re_q),
    .d_o  (d_re),
    .ovf_o(ovf2_re)
  );

  sub2_sat #(.W(Wd), .SAT(SAT)) u_s2_im (
    .a_i  (p_im_q),
    .b_i  (c_im_q),
    .d_o  (d_im),
    .ovf_o(ovf2_im)
  );

  always_comb begin
    s2_adv   = !out_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_adv;
    in_hs    = bus.in_valid && in_ready;
    out_acc  = out_valid_q && bus.out_ready;

    // Stage 1: fill on handshake, empty when it moves on with nothing behind.
    s1_valid_d = s1_valid_q;
    p_re_d     = p_re_q;
    p_im_d     = p_im_q;
    c_re_d     = c_re_q;
    c_im_d     = c_im_q;
    ovf1_d     = ovf1_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      p_re_d     = p_re;
      p_im_d     = p_im;
      c_re_d     = bus.c_Re;
      c_im_d     = bus.c_Im;
      ovf1_d     = ovf1_re | ovf1_im;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // Output stage: data only changes when a real sample moves in, so the
    // result holds still while stalled and after it has been taken.
    out_valid_d = out_valid_q;
    d_re_d      = d_re_q;
    d_im_d      = d_im_q;
    ovf_d       = ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        d_re_d = d_re;
        d_im_d = d_im;
        ovf_d  = ovf1_q | ovf2_re | ovf2_im;
      end
    end

    sticky_d = sticky_q;
    if (out_acc && ovf_q) begin
      sticky_d = 1'b1;
    end else if (bus.ovf_clr) begin
      sticky_d = 1'b0;
    end

    count_d = out_acc ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      p_re_q      <= '0;
      p_im_q      <= '0;
      c_re_q      <= '0;
      c_im_q      <= '0;
      ovf1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      d_re_q      <= '0;
      d_im_q      <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_re_q      <= p_re_d;
      p_im_q      <= p_im_d;
      c_re_q      <= c_re_d;
      c_im_q      <= c_im_d;
      ovf1_q      <= ovf1_d;
      out_valid_q <= out_valid_d;
      d_re_q      <= d_re_d;
      d_im_q      <= d_im_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.d_Re       = d_re_q;
  assign bus.d_Im       = d_im_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.out_count  = count_q;

endmodule

// File: tb/tb_sub3_complex_pipe.sv
// Bench for sub3_complex_pipe. Two instances share one stimulus stream:
// u_dut_wrap (SAT=0, CNT_W=16) and u_dut_sat (SAT=1, CNT_W=2). Expected
// results for both are pushed to a scoreboard at the input handshake and
// popped when the output is taken.
module tb_sub3_complex_pipe;
  import sub3_complex_pkg::*;

  logic clk;
  logic rst_n;

  sub3_complex_pipe_if #(.W(6), .CNT_W(16)) bus0 ();
  sub3_complex_pipe_if #(.W(6), .CNT_W(2))  bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a_Re      = bus0.a_Re;
  assign bus1.a_Im      = bus0.a_Im;
  assign bus1.b_Re      = bus0.b_Re;
  assign bus1.b_Im      = bus0.b_Im;
  assign bus1.c_Re      = bus0.c_Re;
  assign bus1.c_Im      = bus0.c_Im;
  assign bus1.out_ready = bus0.out_ready;
  assign bus1.ovf_clr   = bus0.ovf_clr;

  sub3_complex_pipe #(.QI(3), .QF(3), .SAT(0), .CNT_W(16)) u_dut_wrap (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  sub3_complex_pipe #(.QI(3), .QF(3), .SAT(1), .CNT_W(2)) u_dut_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int re0;
    int im0;
    bit ov0;
    int re1;
    int im1;
    bit ov1;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  bit   hold_v = 1'b0;
  int   held_re, held_im, held_ov;
  bit   done_flag;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Range-based reference: wrap by one span or clamp to the rails.
  function automatic int fix(input int v, input bit sat, inout bit o);
    int span;
    span = MAXV - MINV + 1;
    if (v > MAXV) begin
      o = 1'b1;
      return sat ? MAXV : v - span;
    end
    if (v < MINV) begin
      o = 1'b1;
      return sat ? MINV : v + span;
    end
    return v;
  endfunction

  task automatic send(input int are, input int aim, input int bre, input int bim,
                      input int cre, input int cim);
    exp_t e;
    bit   o0;
    bit   o1;
    bus0.a_Re     = 6'(are);
    bus0.a_Im     = 6'(aim);
    bus0.b_Re     = 6'(bre);
    bus0.b_Im     = 6'(bim);
    bus0.c_Re     = 6'(cre);
    bus0.c_Im     = 6'(cim);
    bus0.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        o0 = 1'b0;
        o1 = 1'b0;
        e.re0 = fix(fix(are - bre, 1'b0, o0) - cre, 1'b0, o0);
        e.im0 = fix(fix(aim - bim, 1'b0, o0) - cim, 1'b0, o0);
        e.re1 = fix(fix(are - bre, 1'b1, o1) - cre, 1'b1, o1);
        e.im1 = fix(fix(aim - bim, 1'b1, o1) - cim, 1'b1, o1);
        e.ov0 = o0;
        e.ov1 = o1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    bus0.in_valid = 1'b0;
  endtask

  // Waits for out_valid (sampled #1 after each edge); returns edges waited.
  task automatic wait_out(output int cycles);
    cycles = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus0.out_valid) return;
    end
    check("wait_out_timeout", 0, 1);
  endtask

  task automatic drain();
    bus0.out_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !bus0.out_valid) return;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  function automatic int rnd();
    return int'($urandom_range(63)) - 32;
  endfunction

  // Output monitor: an output seen valid+ready at the falling edge is taken
  // on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus0.out_valid) begin
          if (hold_v) begin
            check("stall_d_re", int'(bus0.d_Re), held_re);
            check("stall_d_im", int'(bus0.d_Im), held_im);
            check("stall_ovf", int'(bus0.ovf), held_ov);
          end
          if (bus0.out_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_out", 1, 0);
            end else begin
              e = sb.pop_front();
              check("d_re_wrap", int'(bus0.d_Re), e.re0);
              check("d_im_wrap", int'(bus0.d_Im), e.im0);
              check("ovf_wrap", int'(bus0.ovf), int'(e.ov0));
              check("valid_sat", int'(bus1.out_valid), 1);
              check("d_re_sat", int'(bus1.d_Re), e.re1);
              check("d_im_sat", int'(bus1.d_Im), e.im1);
              check("ovf_sat", int'(bus1.ovf), int'(e.ov1));
              acc_cnt++;
            end
          end
        end
        hold_v  = bus0.out_valid && !bus0.out_ready;
        held_re = int'(bus0.d_Re);
        held_im = int'(bus0.d_Im);
        held_ov = int'(bus0.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    rst_n          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    bus0.ovf_clr   = 1'b0;
    bus0.a_Re = '0; bus0.a_Im = '0; bus0.b_Re = '0;
    bus0.b_Im = '0; bus0.c_Re = '0; bus0.c_Im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus0.out_valid), 0);
    check("rst_d_re", int'(bus0.d_Re), 0);
    check("rst_d_im", int'(bus0.d_Im), 0);
    check("rst_ovf", int'(bus0.ovf), 0);
    check("rst_sticky", int'(bus0.ovf_sticky), 0);
    check("rst_count", int'(bus0.out_count), 0);
    check("rst_in_ready", int'(bus0.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic: latency and value
    send(8, 8, 4, -4, 2, 0);
    check("lat_not_early", int'(bus0.out_valid), 0);
    wait_out(cyc);
    check("latency", cyc, 1);
    check("basic_d_re", int'(bus0.d_Re), 2);
    check("basic_d_im", int'(bus0.d_Im), 12);
    check("basic_ovf", int'(bus0.ovf), 0);

    // Stage-1 wrap
    send(31, 0, -1, 0, 0, 0);
    wait_out(cyc);
    check("s1wrap_d_re", int'(bus0.d_Re), -32);
    check("s1wrap_ovf", int'(bus0.ovf), 1);
    check("s1sat_d_re", int'(bus1.d_Re), 31);
    check("s1sat_ovf", int'(bus1.ovf), 1);
    @(posedge clk);
    #1;
    check("s1wrap_sticky", int'(bus0.ovf_sticky), 1);

    // Stage-2 wrap
    send(-20, 0, 10, 0, 5, 0);
    wait_out(cyc);
    check("s2wrap_d_re", int'(bus0.d_Re), 29);
    check("s2wrap_ovf", int'(bus0.ovf), 1);
    check("s2sat_d_re", int'(bus1.d_Re), -32);
    drain();

    // Backpressure: two held, then in_ready drops
    base = acc_cnt;
    bus0.out_ready = 1'b0;
    send(1, 2, 3, 4, 5, 6);
    send(-7, 8, -9, 10, 11, -12);
    check("bp_in_ready_low", int'(bus0.in_ready), 0);
    fork
      begin
        send(20, -20, -15, 15, 1, -1);
        send(0, 0, 31, -32, 1, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", acc_cnt - base, 4);
    check("bp_out_count", int'(bus0.out_count), acc_cnt % 65536);

    // Random traffic with random backpressure
    done_flag = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(posedge clk);
          #1;
          bus0.out_ready = 1'($urandom_range(1));
        end
      end
    join
    drain();
    check("rand_count_wrap", int'(bus0.out_count), acc_cnt % 65536);
    check("rand_count_sat", int'(bus1.out_count), acc_cnt % 4);

    // Sticky: set wins over clear in the same cycle, later clear works
    bus0.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus0.ovf_clr = 1'b0;
    check("clr_sticky", int'(bus0.ovf_sticky), 0);
    bus0.out_ready = 1'b0;
    send(31, 0, -1, 0, 0, 0);
    wait_out(cyc);
    bus0.ovf_clr   = 1'b1;
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.ovf_clr = 1'b0;
    check("set_wins_wrap", int'(bus0.ovf_sticky), 1);
    check("set_wins_sat", int'(bus1.ovf_sticky), 1);
    bus0.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus0.ovf_clr = 1'b0;
    check("late_clr", int'(bus0.ovf_sticky), 0);
    drain();

    // Reset with two triples in flight
    bus0.out_ready = 1'b0;
    send(3, 3, 1, 1, 1, 1);
    send(4, 4, 1, 1, 1, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_wrap", int'(bus0.out_valid), 0);
    check("midrst_valid_sat", int'(bus1.out_valid), 0);
    check("midrst_count_wrap", int'(bus0.out_count), 0);
    check("midrst_count_sat", int'(bus1.out_count), 0);
    sb.delete();
    acc_cnt = 0;
    hold_v  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postrst_quiet", int'(bus0.out_valid), 0);

    // Counter wrap on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) send(i, -i, 1, 1, 0, 0);
    drain();
    check("wrap_count16", int'(bus0.out_count), 5);
    check("wrap_count2", int'(bus1.out_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sub3_complex_pipe.md
Name: sub3_complex_pipe

Overview:
Streaming complex fixed-point three-operand subtractor: d = a - b - c, in QI.QF two's complement. It is the difference-side counterpart of the combinational three-operand complex adder and feeds the convolution datapath where sample differences are formed. It has a two-stage registered pipeline with valid/ready handshakes on both sides, per-sample overflow, a sticky overflow flag and an accepted-output counter.

Parameters:
QI, 3, integer bits including sign
QF, 3, fractional bits
SAT, 0, 0 = wrap on overflow; 1 = saturate each stage to the max/min representable value
CNT_W, 16, width of the output sample counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input triple valid
in_ready  out  1  block can accept the triple this cycle
a_Re, a_Im, b_Re, b_Im, c_Re, c_Im  in  QI+QF each  signed operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
d_Re, d_Im  out  QI+QF each  signed result
ovf  out  1  overflow occurred in either stage or either component for this result; qualified by out_valid
ovf_sticky  out  1  set by any accepted result with ovf=1
ovf_clr  in  1  synchronous clear of ovf_sticky
out_count  out  CNT_W  number of accepted outputs, modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - All stage valids, out_valid, ovf, ovf_sticky and out_count are 0.
  - d_Re and d_Im are 0.
  - in_ready is 1 after reset.
- Width: W = QI+QF. All arithmetic is W-bit two's complement with no growth.
- Stage 1 (s1) register, loaded on an in_valid & in_ready handshake:
  - p = a - b, computed per component.
  - ovf1 = (sign(a) != sign(b)) && (sign(p) != sign(a)).
- Stage 2 (output) register, loaded when s1 advances:
  - d = p - c.
  - ovf2 = (sign(p) != sign(c)) && (sign(d) != sign(p)).
  - ovf = ovf1 | ovf2, ORed over Re and Im.
- SAT=1:
  - A stage that overflows outputs 2^(W-1)-1 if the minuend was non-negative, otherwise -2^(W-1).
  - The stage-2 check uses the saturated p.
  - The ovf flag is still set.
- Handshake:
  - Each stage advances when it is empty or the next stage advances; the output stage advances on out_ready.
  - in_ready = !s1_valid || s2_advance. This is combinational from out_ready; no skid buffer.
  - Latency is 2 cycles from the input handshake to out_valid when there is no stall.
  - Throughput is 1 result per cycle.
  - While out_valid=1 and out_ready=0, d_Re, d_Im and ovf stay stable.
  - Order is preserved, with no drops or duplicates.
  - At most 2 triples are in flight.
- Counters and sticky flag:
  - out_count increments on each out_valid & out_ready and wraps from all-ones to 0.
  - ovf_sticky is set on an accepted result with ovf=1.
  - ovf_clr clears ovf_sticky. If set and clear happen in the same cycle, set wins.
- Inputs with in_valid=0 are ignored.
- Reset mid-stream discards all in-flight data immediately; nothing is emitted afterwards.

Decomposition:
- Package sub3_complex_pkg: W = QI+QF, MAXV/MINV constants, and a function for the subtract-with-overflow/saturate rule.
- One natural sub-module: sub2_sat. It is a combinational W-bit subtract that returns result and overflow under SAT, and is instantiated 4 times (2 stages x Re/Im).

Test Plan:
- Basic (QI=QF=3): a=(8,8), b=(4,-4), c=(2,0), out_ready=1. Required: d=(2,12), ovf=0, out_valid exactly 2 cycles after the handshake.
- Stage-1 wrap: a_Re=31, b_Re=-1, c_Re=0, Im all 0. Required: d_Re=-32, ovf=1, ovf_sticky=1. With SAT=1 the required result is d_Re=31 with ovf=1.
- Stage-2 wrap: a_Re=-20, b_Re=10, c_Re=5. Required: d_Re=29, ovf=1. With SAT=1 the required result is d_Re=-32.
- Backpressure: 4 back-to-back triples, out_ready=0 for 3 cycles. Required: in_ready drops after 2 are held, outputs stay stable, all 4 results emerge in order, out_count=4.
- Sticky clear: ovf_clr pulsed in the same cycle as an accepted ovf=1 result. Required: ovf_sticky stays 1. A clear one cycle later drives it to 0.
- Reset and wrap: assert rst_n low with 2 triples in flight. Required: out_valid=0 immediately and out_count=0. With CNT_W=2, 5 accepts give out_count=1.
